alu_cmd_ctrl: RTL and testbench

- Command sequencer directly upstream of the ALU function decoder.
- Parses byte frames from the UART RX path, then drives operands, a 4-bit ALU function code and the ALU enable. The top two function bits select the ALU unit class.
- Captures the ALU result and returns it as two bytes to the UART TX path.
- Includes a result-wait watchdog and a frame-abort path.

---
 rtl/alu_cmd_ctrl_pkg.sv | 43 ++++
 rtl/alu_cmd_watchdog.sv | 33 +++
 rtl/alu_cmd_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_ctrl_pkg.sv
// rtl/alu_cmd_ctrl_pkg.sv - shared state encoding, frame start code and ALU unit classes
`timescale 1ns/1ps
package alu_cmd_ctrl_pkg;

   // State encoding, kept as plain 4-bit codes so other blocks can decode them
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_GET_A    = 4'd1;
   localparam logic [3:0] S_GET_B    = 4'd2;
   localparam logic [3:0] S_GET_FUN  = 4'd3;
   localparam logic [3:0] S_RUN      = 4'd4;
   localparam logic [3:0] S_WAIT_RES = 4'd5;
   localparam logic [3:0] S_SEND_LO  = 4'd6;
   localparam logic [3:0] S_GAP      = 4'd7;
   localparam logic [3:0] S_SEND_HI  = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   typedef enum logic [3:0] {
      ST_IDLE     = S_IDLE,
      ST_GET_A    = S_GET_A,
      ST_GET_B    = S_GET_B,
      ST_GET_FUN  = S_GET_FUN,
      ST_RUN      = S_RUN,
      ST_WAIT_RES = S_WAIT_RES,
      ST_SEND_LO  = S_SEND_LO,
      ST_GAP      = S_GAP,
      ST_SEND_HI  = S_SEND_HI,
      ST_DONE     = S_DONE
   } state_t;

   // Default frame start code
   localparam logic [7:0] DEF_CMD_BYTE = 8'hCC;

   // Unit class carried in ALU_FUN[3:2], shared with the ALU decoder
   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_LOGIC = 2'b01;
   localparam logic [1:0] CLS_CMP   = 2'b10;
   localparam logic [1:0] CLS_SHIFT = 2'b11;

   function automatic logic [1:0] fun_class(input logic [3:0] fun);
      return fun[3:2];
   endfunction

endpackage

// File: rtl/alu_cmd_watchdog.sv
// rtl/alu_cmd_watchdog.sv - result-wait watchdog counter
`timescale 1ns/1ps
module alu_cmd_watchdog
   import alu_cmd_ctrl_pkg::*;
#(
   parameter int TIMEOUT  = 15,
   parameter int TO_WIDTH = 4
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expire
);

   logic [TO_WIDTH-1:0] r_count;

   // Expire on the increment that would take the count to TIMEOUT, so the
   // owner can leave its wait state on exactly the TIMEOUT-th waited cycle.
   assign o_expire = i_inc && (r_count == TO_WIDTH'(TIMEOUT - 1));

   // Counter: clear has priority over increment
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART frame parser driving the ALU and returning its result
`timescale 1ns/1ps
module alu_cmd_ctrl
   import alu_cmd_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    OUT_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] CMD_BYTE   = DATA_WIDTH'(DEF_CMD_BYTE),
   parameter int                    TIMEOUT    = 15,
   parameter int                    TO_WIDTH   = 4
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VALID,
   output logic [DATA_WIDTH-1:0] ALU_A,
   output logic [DATA_WIDTH-1:0] ALU_B,
   output logic [3:0]            ALU_FUN,
   output logic                  ALU_EN,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  ALU_OUT_VALID,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VALID,
   input  logic                  TX_BUSY,
   output logic                  CMD_ERR
);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_alu_a;
   logic [DATA_WIDTH-1:0] r_alu_b;
   logic [3:0]            r_alu_fun;
   logic                  r_alu_en;
   logic [OUT_WIDTH-1:0]  r_result;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_valid;
   logic                  r_cmd_err;

   logic w_wd_clr;
   logic w_wd_inc;
   logic w_wd_expire;
   logic w_tx_accept;

   // Watchdog is cleared while the ALU is being kicked and runs only while a result is outstanding
   assign w_wd_clr    = (r_state == ST_RUN);
   assign w_wd_inc    = (r_state == ST_WAIT_RES) && !ALU_OUT_VALID;
   assign w_tx_accept = r_tx_valid && !TX_BUSY;

   alu_cmd_watchdog #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (TO_WIDTH)
   ) u_watchdog (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_clr    (w_wd_clr),
      .i_inc    (w_wd_inc),
      .o_expire (w_wd_expire)
   );

   // Frame parser, ALU kick, result capture and two-byte TX serialiser
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_fun  <= '0;
         r_alu_en   <= 1'b0;
         r_result   <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_cmd_err  <= 1'b0;
      end else begin
         r_alu_en  <= 1'b0;
         r_cmd_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (RX_D_VALID && (RX_P_DATA == CMD_BYTE)) begin
                  r_state <= ST_GET_A;
               end
            end
            ST_GET_A: begin
               if (RX_D_VALID) begin
                  r_alu_a <= RX_P_DATA;
                  r_state <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (RX_D_VALID) begin
                  r_alu_b <= RX_P_DATA;
                  r_state <= ST_GET_FUN;
               end
            end
            ST_GET_FUN: begin
               if (RX_D_VALID) begin
                  r_alu_fun <= RX_P_DATA[3:0];
                  // Enable is registered so it is high for the whole RUN cycle
                  r_alu_en  <= 1'b1;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_state <= ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               // A result arriving on the expiry cycle still wins
               if (ALU_OUT_VALID) begin
                  r_result   <= ALU_OUT;
                  r_tx_data  <= ALU_OUT[DATA_WIDTH-1:0];
                  r_tx_valid <= 1'b1;
                  r_state    <= ST_SEND_LO;
               end else if (w_wd_expire) begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_SEND_LO: begin
               r_tx_data <= r_result[DATA_WIDTH-1:0];
               if (w_tx_accept) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_tx_data  <= r_result[OUT_WIDTH-1:DATA_WIDTH];
               r_tx_valid <= 1'b1;
               r_state    <= ST_SEND_HI;
            end
            ST_SEND_HI: begin
               if (w_tx_accept) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ALU_A      = r_alu_a;
   assign ALU_B      = r_alu_b;
   assign ALU_FUN    = r_alu_fun;
   assign ALU_EN     = r_alu_en;
   assign TX_P_DATA  = r_tx_data;
   assign TX_D_VALID = r_tx_valid;
   assign CMD_ERR    = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - scoreboard bench for alu_cmd_ctrl
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
   import alu_cmd_ctrl_pkg::*;

   localparam int DW      = 8;
   localparam int OW      = 16;
   localparam int TIMEOUT = 15;
   localparam int TOW     = 4;
   localparam logic [7:0] CMD = 8'hCC;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] RX_P_DATA = '0;
   logic          RX_D_VALID = 1'b0;
   logic [DW-1:0] ALU_A, ALU_B, TX_P_DATA;
   logic [3:0]    ALU_FUN;
   logic          ALU_EN, TX_D_VALID, CMD_ERR;
   logic [OW-1:0] ALU_OUT = '0;
   logic          ALU_OUT_VALID = 1'b0;
   logic          TX_BUSY = 1'b0;

   alu_cmd_ctrl #(
      .DATA_WIDTH (DW),
      .OUT_WIDTH  (OW),
      .CMD_BYTE   (CMD),
      .TIMEOUT    (TIMEOUT),
      .TO_WIDTH   (TOW)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RX_P_DATA     (RX_P_DATA),
      .RX_D_VALID    (RX_D_VALID),
      .ALU_A         (ALU_A),
      .ALU_B         (ALU_B),
      .ALU_FUN       (ALU_FUN),
      .ALU_EN        (ALU_EN),
      .ALU_OUT       (ALU_OUT),
      .ALU_OUT_VALID (ALU_OUT_VALID),
      .TX_P_DATA     (TX_P_DATA),
      .TX_D_VALID    (TX_D_VALID),
      .TX_BUSY       (TX_BUSY),
      .CMD_ERR       (CMD_ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] f;
   } op_t;

   op_t        en_q[$];
   logic [7:0] tx_q[$];
   int         err_q[$];

   int   en_cyc = 0;
   int   fun_cyc = 0;
   int   lo_rise_cyc = 0;
   logic prev_txv = 1'b0;

   int         busy_mode = 0;
   logic       busy_force = 1'b0;
   int         resp_delay = 1;
   logic [15:0] resp_value = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Behavioural ALU used to produce plausible results for random frames
   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      logic [15:0] wa, wb;
      wa = {8'h00, a};
      wb = {8'h00, b};
      case (f[3:2])
         CLS_ARITH: case (f[1:0])
            2'd0: return wa + wb;
            2'd1: return wa - wb;
            2'd2: return wa * wb;
            default: return (b == 8'h00) ? 16'h0000 : wa / wb;
         endcase
         CLS_LOGIC: case (f[1:0])
            2'd0: return wa | wb;
            2'd1: return wa & wb;
            2'd2: return wa ^ wb;
            default: return ~(wa & wb);
         endcase
         CLS_CMP: case (f[1:0])
            2'd0: return (a == b) ? 16'd1 : 16'd0;
            2'd1: return (a > b) ? 16'd1 : 16'd0;
            2'd2: return (a < b) ? 16'd1 : 16'd0;
            default: return 16'd0;
         endcase
         default: case (f[1:0])
            2'd0: return wa << b[2:0];
            2'd1: return wa >> b[2:0];
            2'd2: return {a, b};
            default: return {b, a};
         endcase
      endcase
   endfunction

   // Monitor: every ALU_EN cycle must match the next expected operand set
   always @(negedge CLK) begin
      op_t e;
      if (ALU_EN) begin
         en_cyc = cyc;
         if (en_q.size() == 0) begin
            flag_fail("unexpected_alu_en");
         end else begin
            e = en_q.pop_front();
            chk("alu_a", 32'(ALU_A), 32'(e.a));
            chk("alu_b", 32'(ALU_B), 32'(e.b));
            chk("alu_fun", 32'(ALU_FUN), 32'(e.f));
         end
      end
   end

   // Monitor: TX bytes held while busy, popped when accepted
   always @(negedge CLK) begin
      if (TX_D_VALID) begin
         if (!prev_txv && tx_q.size() == 2) lo_rise_cyc = cyc;
         if (tx_q.size() == 0) begin
            flag_fail("unexpected_tx_valid");
         end else if (TX_BUSY) begin
            chk("tx_hold", 32'(TX_P_DATA), 32'(tx_q[0]));
         end else begin
            chk("tx_byte", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
         end
      end
      prev_txv = TX_D_VALID;
   end

   // Monitor: CMD_ERR pulses must be expected and land TIMEOUT cycles after WAIT_RES entry
   always @(negedge CLK) begin
      if (CMD_ERR) begin
         if (err_q.size() == 0) begin
            flag_fail("unexpected_cmd_err");
         end else begin
            void'(err_q.pop_front());
            chk("cmd_err_cycle", 32'(cyc), 32'(en_cyc + 1 + TIMEOUT));
         end
      end
   end

   // ALU responder: returns resp_value resp_delay cycles after ALU_EN (no reply if delay is huge)
   always @(negedge CLK) begin
      int d;
      logic [15:0] v;
      if (ALU_EN) begin
         d = resp_delay;
         v = resp_value;
         if (d <= 64) begin
            repeat (d) @(posedge CLK);
            #1;
            ALU_OUT_VALID = 1'b1;
            ALU_OUT       = v;
            @(posedge CLK);
            #1;
            ALU_OUT_VALID = 1'b0;
            ALU_OUT       = 16'($urandom);
         end
      end
   end

   // TX_BUSY driver: idle, random, or forced by the directed test
   always @(posedge CLK) begin
      #2;
      case (busy_mode)
         0:       TX_BUSY = 1'b0;
         1:       TX_BUSY = 1'($urandom_range(0, 1));
         default: TX_BUSY = busy_force;
      endcase
   end

   task automatic send_byte(input logic [7:0] b, input bit is_fun);
      @(posedge CLK);
      #1;
      RX_P_DATA  = b;
      RX_D_VALID = 1'b1;
      if (is_fun) fun_cyc = cyc;
      @(posedge CLK);
      #1;
      RX_D_VALID = 1'b0;
      RX_P_DATA  = 8'($urandom);
   endtask

   task automatic wait_done(input bit inject);
      int n;
      logic [7:0] b;
      n = 0;
      while ((tx_q.size() != 0 || err_q.size() != 0 || en_q.size() != 0) && n < 3000) begin
         @(posedge CLK);
         #1;
         n++;
         if (inject && tx_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            b = 8'($urandom);
            if (tx_q.size() < 2 && b == CMD) b = 8'h5A;
            RX_P_DATA  = b;
            RX_D_VALID = 1'b1;
            @(posedge CLK);
            #1;
            RX_D_VALID = 1'b0;
         end
      end
      if (n >= 3000) flag_fail("drain_timeout");
      repeat (3) @(posedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                             input logic [15:0] val, input int delay, input bit inject);
      resp_value = val;
      resp_delay = delay;
      send_byte(CMD, 1'b0);
      send_byte(a, 1'b0);
      send_byte(b, 1'b0);
      en_q.push_back('{a: a, b: b, f: f[3:0]});
      if (delay <= TIMEOUT) begin
         tx_q.push_back(val[7:0]);
         tx_q.push_back(val[15:8]);
      end else begin
         err_q.push_back(1);
      end
      send_byte(f, 1'b1);
      wait_done(inject);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_a"}, 32'(ALU_A), 32'h0);
      chk({tag, "_alu_b"}, 32'(ALU_B), 32'h0);
      chk({tag, "_alu_fun"}, 32'(ALU_FUN), 32'h0);
      chk({tag, "_alu_en"}, 32'(ALU_EN), 32'h0);
      chk({tag, "_tx_data"}, 32'(TX_P_DATA), 32'h0);
      chk({tag, "_tx_valid"}, 32'(TX_D_VALID), 32'h0);
      chk({tag, "_cmd_err"}, 32'(CMD_ERR), 32'h0);
   endtask

   task automatic wait_tx_valid(input string name);
      int n;
      n = 0;
      @(negedge CLK);
      while (!TX_D_VALID && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) flag_fail(name);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "bench stalled");
   end

   initial begin
      logic [7:0] ra, rb, rf, g;
      int rd;

      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(posedge CLK);

      // Basic frame with latency checks
      send_frame(8'h05, 8'h03, 8'h00, 16'h0008, 1, 1'b0);
      chk("en_latency", 32'(en_cyc), 32'(fun_cyc + 1));
      chk("tx_latency", 32'(lo_rise_cyc), 32'(en_cyc + 2));
      chk("hold_alu_a", 32'(ALU_A), 32'h05);
      chk("hold_alu_b", 32'(ALU_B), 32'h03);

      // Garbage before a frame is ignored
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_frame(8'hF0, 8'h0F, 8'h04, 16'h00FF, 1, 1'b0);
      chk("fun_class", 32'(fun_class(ALU_FUN)), 32'(CLS_LOGIC));

      // Timeout, then a normal frame
      send_frame(8'h11, 8'h22, 8'h03, 16'h1234, 1000, 1'b0);
      send_frame(8'h07, 8'h09, 8'h00, 16'h0010, 1, 1'b0);

      // Result on the last waited cycle wins; one cycle later is a timeout
      send_frame(8'h21, 8'h43, 8'h08, 16'h5A5A, TIMEOUT, 1'b0);
      send_frame(8'h65, 8'h87, 8'h09, 16'hA5A5, TIMEOUT + 1, 1'b0);

      // Long TX_BUSY stalls before each byte
      busy_force = 1'b1;
      busy_mode  = 2;
      fork
         send_frame(8'h12, 8'h34, 8'h02, 16'hABCD, 1, 1'b0);
         begin
            wait_tx_valid("wait_lo_valid");
            repeat (20) @(posedge CLK);
            #1;
            busy_force = 1'b0;
            @(posedge CLK);
            #1;
            busy_force = 1'b1;
            wait_tx_valid("wait_hi_valid");
            repeat (20) @(posedge CLK);
            #1;
            busy_force = 1'b0;
         end
      join
      busy_mode = 0;

      // Asynchronous reset mid-frame, then a clean frame
      send_byte(CMD, 1'b0);
      send_byte(8'h02, 1'b0);
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      chk_all_zero("async_reset");
      #3;
      RST = 1'b0;
      send_frame(8'h02, 8'h02, 8'h0C, 16'h0008, 1, 1'b0);
      chk("post_reset_fun", 32'(ALU_FUN), 32'hC);

      // In-frame CMD bytes are data
      send_frame(8'hCC, 8'hCC, 8'h01, 16'h0000, 1, 1'b1);
      chk("cc_alu_a", 32'(ALU_A), 32'hCC);
      chk("cc_alu_b", 32'(ALU_B), 32'hCC);

      // Randomised frames with random backpressure, late results and dropped RX bytes
      for (int i = 0; i < 40; i++) begin
         busy_mode = int'($urandom_range(0, 1));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            g = 8'($urandom);
            if (g == CMD) g = 8'h33;
            send_byte(g, 1'b0);
         end
         ra = 8'($urandom);
         rb = 8'($urandom);
         rf = 8'($urandom);
         rd = int'($urandom_range(1, TIMEOUT + 2));
         send_frame(ra, rb, rf, alu_ref(ra, rb, rf[3:0]), rd, 1'b1);
      end

      busy_mode = 0;
      repeat (5) @(posedge CLK);
      chk("en_q_empty", 32'(en_q.size()), 32'h0);
      chk("tx_q_empty", 32'(tx_q.size()), 32'h0);
      chk("err_q_empty", 32'(err_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
